lzma_obuf_stream_sink: RTL and testbench

- Receiving end of the compressor's output stream (valid/data/last, no backpressure).
- Buffers compressed bytes in an on-chip FIFO and re-emits them as a ready/valid byte stream, so a slow consumer (UART, DMA, host bridge) can drain the compressed output.
- Flags bytes lost when the compressor pushes into a full buffer.

---
 rtl/lzma_obuf_stream_sink_if.sv | 21 ++
 rtl/lzma_obuf_stream_sink.sv | 111 +++++++++++
 tb/tb_lzma_obuf_stream_sink.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzma_obuf_stream_sink_if.sv
// Byte stream bundle for the compressor output sink: push side without
// backpressure, drain side with a valid/ready handshake.
interface lzma_obuf_stream_sink_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_last;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;

    modport master (
        output i_valid, i_data, i_last, o_ready,
        input  o_valid, o_data, o_last
    );

    modport slave (
        input  i_valid, i_data, i_last, o_ready,
        output o_valid, o_data, o_last
    );
endinterface

// File: rtl/lzma_obuf_stream_sink.sv
// Compressed-byte sink: BRAM FIFO re-emitted as a ready/valid stream.
// Optional frame length reporting enabled by LZMA_OBUF_FRAME_LEN_EN.
module lzma_obuf_stream_sink #(
    parameter int DEPTH_LOG = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    lzma_obuf_stream_sink_if.slave s,
    output logic                   o_overflow,
    output logic [DEPTH_LOG:0]     o_level,
    output logic                   f_valid,
    output logic [31:0]            f_len
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_LVL = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] LVL_ONE = (DEPTH_LOG+1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

    logic [8:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [8:0]           rd_data;
    logic                 mid_valid;
    logic                 full;
    logic                 wr_en;
    logic                 xfer;
    logic                 mid_move;
    logic                 rd_en;
    logic [DEPTH_LOG:0]   mem_cnt;

    // mid stage is the BRAM output register; o_level also counts it
    always_comb begin
        full     = (o_level == FULL_LVL);
        wr_en    = s.i_valid && !full;
        xfer     = s.o_valid && s.o_ready;
        mid_move = mid_valid && (!s.o_valid || xfer);
        mem_cnt  = o_level - (DEPTH_LOG+1)'(s.o_valid)
                           - (DEPTH_LOG+1)'(mid_valid);
        rd_en    = (mem_cnt != '0) && (!mid_valid || mid_move);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s.i_last, s.i_data};
        if (rd_en)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mid_valid  <= 1'b0;
            s.o_valid  <= 1'b0;
            s.o_data   <= 8'h00;
            s.o_last   <= 1'b0;
            o_overflow <= 1'b0;
            o_level    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_en)
                mid_valid <= 1'b1;
            else if (mid_move)
                mid_valid <= 1'b0;
            if (mid_move) begin
                s.o_valid <= 1'b1;
                s.o_last  <= rd_data[8];
                s.o_data  <= rd_data[7:0];
            end else if (xfer) begin
                s.o_valid <= 1'b0;
            end
            if (s.i_valid && full)
                o_overflow <= 1'b1;
            if (wr_en && !xfer)
                o_level <= o_level + LVL_ONE;
            else if (!wr_en && xfer)
                o_level <= o_level - LVL_ONE;
        end
    end

`ifdef LZMA_OBUF_FRAME_LEN_EN
    logic [31:0] frame_cnt;
    logic [31:0] cnt_inc;

    assign cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + 32'd1;

    // a dropped last byte still closes the frame, reporting accepted bytes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 32'd0;
            f_valid   <= 1'b0;
            f_len     <= 32'd0;
        end else begin
            f_valid <= 1'b0;
            if (s.i_valid && s.i_last) begin
                f_valid   <= 1'b1;
                f_len     <= wr_en ? cnt_inc : frame_cnt;
                frame_cnt <= 32'd0;
            end else if (wr_en) begin
                frame_cnt <= cnt_inc;
            end
        end
    end
`else
    assign f_valid = 1'b0;
    assign f_len   = 32'd0;
`endif
endmodule

// File: tb/tb_lzma_obuf_stream_sink.sv
// Bench: two sinks (DEPTH_LOG 10 and 4) on one stimulus, each checked
// against a queue model of arrival time, capacity and handshake rules.
module tb_lzma_obuf_stream_sink;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_last = 1'b0;
    logic       o_ready = 1'b0;
    logic [7:0] i_data = 8'h00;

    always #5 clk = ~clk;

    lzma_obuf_stream_sink_if bif ();
    lzma_obuf_stream_sink_if sif ();

    assign bif.i_valid = i_valid;
    assign bif.i_data  = i_data;
    assign bif.i_last  = i_last;
    assign bif.o_ready = o_ready;
    assign sif.i_valid = i_valid;
    assign sif.i_data  = i_data;
    assign sif.i_last  = i_last;
    assign sif.o_ready = o_ready;

    logic        ovf_b, ovf_s, fv_b, fv_s;
    logic [10:0] lvl_b;
    logic [4:0]  lvl_s;
    logic [31:0] fl_b, fl_s;

    lzma_obuf_stream_sink #(.DEPTH_LOG(10)) u_big (
        .clk(clk), .rstn(rstn), .s(bif.slave),
        .o_overflow(ovf_b), .o_level(lvl_b),
        .f_valid(fv_b), .f_len(fl_b)
    );

    lzma_obuf_stream_sink #(.DEPTH_LOG(4)) u_small (
        .clk(clk), .rstn(rstn), .s(sif.slave),
        .o_overflow(ovf_s), .o_level(lvl_s),
        .f_valid(fv_s), .f_len(fl_s)
    );

    logic [60:0] obs_b, obs_s;
    assign obs_b = {bif.o_valid,
                    bif.o_valid ? {bif.o_last, bif.o_data} : 9'h0,
                    ovf_b, 17'(lvl_b), fv_b, fl_b};
    assign obs_s = {sif.o_valid,
                    sif.o_valid ? {sif.o_last, sif.o_data} : 9'h0,
                    ovf_s, 17'(lvl_s), fv_s, fl_s};

    int checks = 0;
    int failures = 0;
    int e = 0;

    // model: per sink a byte queue with write edge of each entry
    logic [8:0]  md [2][4096];
    int          mw [2][4096];
    int          hd [2];
    int          tl [2];
    int          lx [2];
    int          cap [2] = '{1024, 16};
    bit          ov [2];
    longint      cnt [2];
    bit          fv [2];
    logic [31:0] fl [2];

    logic [8:0] got_b [4096];
    logic [8:0] got_s [4096];
    int         ng_b = 0;
    int         ng_s = 0;

    // a byte shows 2 edges after its write, never before its predecessor left
    function automatic bit vis(int m);
        if (tl[m] == hd[m]) return 1'b0;
        return (e >= mw[m][hd[m] % 4096] + 2) && (e >= lx[m]);
    endfunction

    function automatic logic [60:0] expv(int m);
        bit v;
        logic [8:0] h;
        v = vis(m);
        h = v ? md[m][hd[m] % 4096] : 9'h0;
        return {v, h, ov[m], 17'(tl[m] - hd[m]), fv[m], fl[m]};
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            hd[m] = 0; tl[m] = 0; lx[m] = e;
            ov[m] = 1'b0; cnt[m] = 0; fv[m] = 1'b0; fl[m] = 32'd0;
        end
    endtask

    task automatic step();
        bit pv [2];
        bit full, xf, wr;
        pv[0] = vis(0);
        pv[1] = vis(1);
        if (bif.o_valid && o_ready && ng_b < 4096) begin
            got_b[ng_b] = {bif.o_last, bif.o_data};
            ng_b++;
        end
        if (sif.o_valid && o_ready && ng_s < 4096) begin
            got_s[ng_s] = {sif.o_last, sif.o_data};
            ng_s++;
        end
        @(posedge clk);
        e++;
        for (int m = 0; m < 2; m++) begin
            full = ((tl[m] - hd[m]) == cap[m]);
            xf = pv[m] && o_ready;
            wr = i_valid && !full;
            if (i_valid && full) ov[m] = 1'b1;
`ifdef LZMA_OBUF_FRAME_LEN_EN
            if (i_valid && i_last) begin
                fv[m] = 1'b1;
                fl[m] = wr ? 32'((cnt[m] + 1 > 64'hFFFFFFFF) ? cnt[m] : cnt[m] + 1)
                           : 32'(cnt[m]);
                cnt[m] = 0;
            end else begin
                fv[m] = 1'b0;
                if (wr && cnt[m] < 64'hFFFFFFFF) cnt[m]++;
            end
`endif
            if (xf) begin
                hd[m]++;
                lx[m] = e;
            end
            if (wr) begin
                md[m][tl[m] % 4096] = {i_last, i_data};
                mw[m][tl[m] % 4096] = e;
                tl[m]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        mreset();
        ng_b = 0;
        ng_s = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        checks++;
        if ({obs_b, obs_s} !== 122'h0) begin
            failures++;
            $display("FAIL reset got=%h exp=0", {obs_b, obs_s});
        end
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        mreset();
    endtask

    task automatic test_basic();
        int w0, v0;
        v0 = -1;
        ng_b = 0;
        o_ready = 1'b1;
        for (int j = 0; j < 13; j++) begin
            i_valid = (j < 5);
            i_data = 8'h11 + 8'(j);
            i_last = (j == 4);
            step();
            if (j == 0) w0 = e;
            if (bif.o_valid && v0 < 0) v0 = e;
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL basic e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
        end
        checks++;
        if (v0 - w0 != 2) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=2", v0 - w0);
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (ng_b != 5 || got_b[j] !== {(j == 4), 8'h11 + 8'(j)}) begin
                failures++;
                $display("FAIL basic_order j=%0d got=%h exp=%h n=%0d", j,
                         got_b[j], {(j == 4), 8'h11 + 8'(j)}, ng_b);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] ref_d [8];
        ng_b = 0;
        o_ready = 1'b0;
        for (int j = 0; j < 32; j++) begin
            i_valid = (j < 8);
            i_data = 8'($urandom);
            i_last = 1'b0;
            if (j < 8) ref_d[j] = i_data;
            if (j >= 8) o_ready = (j % 2 == 0);
            step();
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL stall e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
            if (j == 7) begin
                checks++;
                if (lvl_b !== 11'd8) begin
                    failures++;
                    $display("FAIL stall_level got=%0d exp=8", lvl_b);
                end
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (ng_b != 8 || got_b[j] !== {1'b0, ref_d[j]}) begin
                failures++;
                $display("FAIL stall_order j=%0d got=%h exp=%h n=%0d", j,
                         got_b[j], {1'b0, ref_d[j]}, ng_b);
            end
        end
        checks++;
        if (lvl_b !== 11'd0) begin
            failures++;
            $display("FAIL stall_drain got=%0d exp=0", lvl_b);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        o_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            i_valid = 1'b1;
            i_data = 8'(j);
            i_last = (j == 19);
            step();
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL overflow e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
            if (j == 15 || j == 16) begin
                checks++;
                if (ovf_s !== (j == 16)) begin
                    failures++;
                    $display("FAIL overflow_flag push=%0d got=%b", j + 1, ovf_s);
                end
            end
        end
        i_valid = 1'b0;
        checks++;
        if (lvl_s !== 5'd16 || ovf_s !== 1'b1 || lvl_b !== 11'd20 || ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL overflow_full got=%0d/%b/%0d/%b exp=16/1/20/0",
                     lvl_s, ovf_s, lvl_b, ovf_b);
        end
`ifdef LZMA_OBUF_FRAME_LEN_EN
        checks++;
        if (fl_s !== 32'd16 || fl_b !== 32'd20) begin
            failures++;
            $display("FAIL overflow_flen got=%0d/%0d exp=16/20", fl_s, fl_b);
        end
`endif
    endtask

    task automatic test_full_rw();
        i_valid = 1'b1;
        i_data = 8'h55;
        i_last = 1'b0;
        o_ready = 1'b1;
        step();
        i_valid = 1'b0;
        checks++;
        if (lvl_s !== 5'd15 || ovf_s !== 1'b1) begin
            failures++;
            $display("FAIL full_rw got=%0d/%b exp=15/1", lvl_s, ovf_s);
        end
        for (int j = 0; j < 40; j++) begin
            step();
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL full_drain e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (ng_s != 16 || got_s[j] !== {1'b0, 8'(j)}) begin
                failures++;
                $display("FAIL full_order j=%0d got=%h exp=%h n=%0d", j,
                         got_s[j], {1'b0, 8'(j)}, ng_s);
            end
        end
    endtask

    task automatic test_frame();
        int np;
        int pl [4];
        np = 0;
        do_reset();
        o_ready = 1'b1;
        for (int j = 0; j < 310; j++) begin
            i_valid = (j < 301);
            i_data = 8'($urandom);
            i_last = (j == 299) || (j == 300);
            step();
            if (fv_b) begin
                if (np < 4) pl[np] = int'(fl_b);
                np++;
            end
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL frame e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
        end
`ifdef LZMA_OBUF_FRAME_LEN_EN
        checks++;
        if (np != 2 || pl[0] != 300 || pl[1] != 1) begin
            failures++;
            $display("FAIL frame_len got=%0d:%0d,%0d exp=2:300,1",
                     np, pl[0], pl[1]);
        end
`else
        checks++;
        if (np != 0) begin
            failures++;
            $display("FAIL frame_len_off got=%0d exp=0", np);
        end
`endif
    endtask

    task automatic test_random();
        int pr, pv;
        for (int j = 0; j < 800; j++) begin
            pr = (j / 200 == 1) ? 1 : ((j / 200 == 2) ? 9 : 5);
            pv = (j / 200 == 3) ? 3 : 7;
            i_valid = ($urandom_range(0, 9) < pv);
            i_data = 8'($urandom);
            i_last = ($urandom_range(0, 15) == 0);
            o_ready = ($urandom_range(0, 9) < pr);
            step();
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL random e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        o_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            i_valid = 1'b1;
            i_data = 8'($urandom);
            i_last = 1'b0;
            step();
        end
        i_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({obs_b, obs_s} !== 122'h0) begin
            failures++;
            $display("FAIL midreset got=%h exp=0", {obs_b, obs_s});
        end
        #1 rstn = 1'b1;
        mreset();
        ng_b = 0;
        ng_s = 0;
        o_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            i_valid = (j >= 4 && j < 7);
            i_data = 8'hA0 + 8'(j - 4);
            i_last = (j == 6);
            step();
            checks++;
            if ({obs_b, obs_s} !== {expv(0), expv(1)}) begin
                failures++;
                $display("FAIL post_reset e=%0d got=%h exp=%h", e,
                         {obs_b, obs_s}, {expv(0), expv(1)});
            end
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ng_b != 3 || got_b[j] !== {(j == 2), 8'hA0 + 8'(j)}) begin
                failures++;
                $display("FAIL post_reset_order j=%0d got=%h exp=%h n=%0d", j,
                         got_b[j], {(j == 2), 8'hA0 + 8'(j)}, ng_b);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_full_rw();
        test_frame();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
